call_ret_sequencer: RTL and testbench

Program-counter sequencer for the 2-stage (fetch/execute) pipelined MCU, and the initiating end of the return-address stack interface. It consumes decoded control ops from the execute stage and issues stack push/pop with the return address. It consumes the stack's combinational top-of-stack on returns. It produces the next fetch PC, squashes wrongly-fetched instructions, vectors interrupts, and tracks stack depth with sticky overflow and underflow flags.

---
 rtl/mcu_pkg.sv | 25 ++
 rtl/stk_depth_tracker.sv | 52 +++++
 rtl/call_ret_sequencer.sv | 124 ++++++++++++
 tb/tb_call_ret_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared widths, vectors and next-PC select encoding for the call/return sequencer.
package mcu_pkg;

    localparam int unsigned PC_W      = 11;
    localparam int unsigned STK_DEPTH = 16;
    localparam int unsigned DEPTH_W   = 5;

    localparam logic [PC_W-1:0]    RESET_VECTOR = 11'h000;
    localparam logic [PC_W-1:0]    INT_VECTOR   = 11'h004;
    localparam logic [DEPTH_W-1:0] STK_FULL     = DEPTH_W'(STK_DEPTH);

    typedef enum logic [2:0] {
        NpcInc,
        NpcTarget,
        NpcStack,
        NpcVector,
        NpcHold
    } npc_sel_e;

    // PC arithmetic wraps at PC_W bits.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] a);
        return a + PC_W'(1);
    endfunction

endpackage

// File: rtl/stk_depth_tracker.sv
// Return-stack occupancy counter with sticky overflow/underflow flags.
module stk_depth_tracker
    import mcu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic               err_clr,
    output logic [DEPTH_W-1:0] depth,
    output logic               overflow,
    output logic               underflow
);

    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               ovf_set, unf_set;

    always_comb begin
        depth_d = depth_q;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (push) begin
            if (depth_q == STK_FULL) ovf_set = 1'b1;
            else                     depth_d = depth_q + DEPTH_W'(1);
        end else if (pop) begin
            if (depth_q == '0) unf_set = 1'b1;
            else               depth_d = depth_q - DEPTH_W'(1);
        end
        // A fresh error in the clearing cycle keeps the flag set.
        ovf_d = (ovf_q & ~err_clr) | ovf_set;
        unf_d = (unf_q & ~err_clr) | unf_set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign depth     = depth_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: rtl/call_ret_sequencer.sv
// Fetch-PC sequencer: CALL/GOTO/RETURN/skip/interrupt redirects with one-bubble flush,
// return-stack push/pop strobes and depth tracking.
module call_ret_sequencer
    import mcu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               ex_call,
    input  logic               ex_goto,
    input  logic               ex_ret,
    input  logic               ex_retfie,
    input  logic               ex_skip,
    input  logic [PC_W-1:0]    ex_target,
    input  logic [PC_W-1:0]    ex_pc,
    input  logic               int_req,
    input  logic               int_en,
    input  logic [PC_W-1:0]    stack_out,
    input  logic               err_clr,
    output logic [PC_W-1:0]    pc,
    output logic               stack_push,
    output logic               stack_pop,
    output logic [PC_W-1:0]    stack_data,
    output logic               flush,
    output logic               int_ack,
    output logic [DEPTH_W-1:0] depth,
    output logic               stk_overflow,
    output logic               stk_underflow
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic            flush_q, flush_d;
    logic            int_ack_q, int_ack_d;
    logic            int_active_q, int_active_d;
    npc_sel_e        sel;
    logic            push, pop;
    logic [PC_W-1:0] push_data;

    // Priority: call > goto > return > skip > interrupt > sequential.
    always_comb begin
        sel          = NpcInc;
        flush_d      = 1'b0;
        int_ack_d    = 1'b0;
        int_active_d = int_active_q;
        push         = 1'b0;
        pop          = 1'b0;
        push_data    = '0;
        if (stall) begin
            sel     = NpcHold;
            flush_d = flush_q;
        end else if (flush_q) begin
            sel = NpcInc;
        end else if (ex_call) begin
            push      = 1'b1;
            push_data = pc_inc(ex_pc);
            sel       = NpcTarget;
            flush_d   = 1'b1;
        end else if (ex_goto) begin
            sel     = NpcTarget;
            flush_d = 1'b1;
        end else if (ex_ret || ex_retfie) begin
            pop     = 1'b1;
            sel     = NpcStack;
            flush_d = 1'b1;
            if (ex_retfie) int_active_d = 1'b0;
        end else if (ex_skip) begin
            sel     = NpcInc;
            flush_d = 1'b1;
        end else if (int_req && int_en && !int_active_q) begin
            // The fetched instruction is squashed, so its address is the return point.
            push         = 1'b1;
            push_data    = pc_q;
            sel          = NpcVector;
            flush_d      = 1'b1;
            int_ack_d    = 1'b1;
            int_active_d = 1'b1;
        end
    end

    always_comb begin
        pc_d = pc_q;
        unique case (sel)
            NpcInc:    pc_d = pc_inc(pc_q);
            NpcTarget: pc_d = ex_target;
            NpcStack:  pc_d = stack_out;
            NpcVector: pc_d = INT_VECTOR;
            NpcHold:   pc_d = pc_q;
            default:   pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= RESET_VECTOR;
            flush_q      <= 1'b1;
            int_ack_q    <= 1'b0;
            int_active_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            flush_q      <= flush_d;
            int_ack_q    <= int_ack_d;
            int_active_q <= int_active_d;
        end
    end

    assign stack_push = push & ~reset;
    assign stack_pop  = pop & ~reset;
    assign stack_data = stack_push ? push_data : '0;
    assign pc         = pc_q;
    assign flush      = flush_q;
    assign int_ack    = int_ack_q;

    stk_depth_tracker u_depth (
        .clk       (clk),
        .reset     (reset),
        .push      (stack_push),
        .pop       (stack_pop),
        .err_clr   (err_clr),
        .depth     (depth),
        .overflow  (stk_overflow),
        .underflow (stk_underflow)
    );

endmodule

// File: tb/tb_call_ret_sequencer.sv
// Directed bench for call_ret_sequencer: cycle-by-cycle vector table plus
// hand-written reset, stack saturation and flag-clear sequences.
module tb_call_ret_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, ex_call, ex_goto, ex_ret, ex_retfie, ex_skip;
    logic [10:0] ex_target, ex_pc, stack_out;
    logic        int_req, int_en, err_clr;
    logic [10:0] pc, stack_data;
    logic        stack_push, stack_pop, flush, int_ack;
    logic [4:0]  depth;
    logic        stk_overflow, stk_underflow;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    call_ret_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .ex_call       (ex_call),
        .ex_goto       (ex_goto),
        .ex_ret        (ex_ret),
        .ex_retfie     (ex_retfie),
        .ex_skip       (ex_skip),
        .ex_target     (ex_target),
        .ex_pc         (ex_pc),
        .int_req       (int_req),
        .int_en        (int_en),
        .stack_out     (stack_out),
        .err_clr       (err_clr),
        .pc            (pc),
        .stack_push    (stack_push),
        .stack_pop     (stack_pop),
        .stack_data    (stack_data),
        .flush         (flush),
        .int_ack       (int_ack),
        .depth         (depth),
        .stk_overflow  (stk_overflow),
        .stk_underflow (stk_underflow)
    );

    // op: 0 nop, 1 call, 2 goto, 3 ret, 4 retfie, 5 skip, 6 call+ret (illegal combo)
    typedef struct {
        int          op;
        logic        st, irq, ien, clr;
        logic [10:0] tgt, xpc, sout;
        logic [10:0] e_pc;
        logic        e_fl, e_ack, e_push, e_pop;
        logic [10:0] e_data;
        logic [4:0]  e_dep;
        logic        e_ovf, e_unf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int op, int st, int irq, int ien, int clr, int tgt, int xpc,
                                int sout, int e_pc, int e_fl, int e_ack, int e_push,
                                int e_pop, int e_data, int e_dep, int e_ovf, int e_unf);
        vec_t r;
        r.op = op;
        r.st = 1'(st);       r.irq = 1'(irq);     r.ien = 1'(ien);     r.clr = 1'(clr);
        r.tgt = 11'(tgt);    r.xpc = 11'(xpc);    r.sout = 11'(sout);
        r.e_pc = 11'(e_pc);  r.e_fl = 1'(e_fl);   r.e_ack = 1'(e_ack);
        r.e_push = 1'(e_push); r.e_pop = 1'(e_pop); r.e_data = 11'(e_data);
        r.e_dep = 5'(e_dep); r.e_ovf = 1'(e_ovf); r.e_unf = 1'(e_unf);
        return r;
    endfunction

    task automatic chk(input string name, input logic [32:0] got, input logic [32:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        stall = 0; ex_call = 0; ex_goto = 0; ex_ret = 0; ex_retfie = 0; ex_skip = 0;
        ex_target = '0; ex_pc = '0; stack_out = '0; int_req = 0; int_en = 0; err_clr = 0;
    endtask

    task automatic drive(input vec_t v);
        stall     = v.st;
        ex_call   = (v.op == 1) || (v.op == 6);
        ex_goto   = (v.op == 2);
        ex_ret    = (v.op == 3) || (v.op == 6);
        ex_retfie = (v.op == 4);
        ex_skip   = (v.op == 5);
        ex_target = v.tgt;
        ex_pc     = v.xpc;
        stack_out = v.sout;
        int_req   = v.irq;
        int_en    = v.ien;
        err_clr   = v.clr;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        //                 op st iq ie cl  tgt    xpc    sout  | pc    fl ak pu po data  dep ov un
        vecs.push_back(mk(0, 0, 0, 0, 0, 'h000, 'h000, 'h000, 'h000, 1, 0, 0, 0, 'h000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 'h000, 'h000, 'h000, 'h001, 0, 0, 0, 0, 'h000, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 'h120, 'h010, 'h000, 'h002, 0, 0, 1, 0, 'h011, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 'h300, 'h120, 'h000, 'h120, 1, 0, 0, 0, 'h000, 1, 0, 0));
        vecs.push_back(mk(3, 0, 0, 0, 0, 'h000, 'h121, 'h011, 'h121, 0, 0, 0, 1, 'h000, 1, 0, 0));
        vecs.push_back(mk(3, 0, 0, 0, 0, 'h000, 'h011, 'h333, 'h011, 1, 0, 0, 0, 'h000, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 0, 0, 'h050, 'h011, 'h000, 'h012, 0, 0, 0, 0, 'h000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 'h000, 'h000, 'h000, 'h050, 1, 0, 0, 0, 'h000, 0, 0, 0));
        vecs.push_back(mk(5, 0, 0, 0, 0, 'h000, 'h050, 'h000, 'h051, 0, 0, 0, 0, 'h000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 'h000, 'h000, 'h000, 'h052, 1, 0, 0, 0, 'h000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 'h000, 'h000, 'h000, 'h053, 0, 0, 0, 0, 'h000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 'h000, 'h000, 'h000, 'h054, 0, 0, 0, 0, 'h000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 'h000, 'h000, 'h000, 'h055, 0, 0, 1, 0, 'h055, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 'h000, 'h000, 'h000, 'h004, 1, 1, 0, 0, 'h000, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 'h000, 'h000, 'h000, 'h005, 0, 0, 0, 0, 'h000, 1, 0, 0));
        vecs.push_back(mk(4, 0, 1, 1, 0, 'h000, 'h005, 'h055, 'h006, 0, 0, 0, 1, 'h000, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 'h000, 'h000, 'h000, 'h055, 1, 0, 0, 0, 'h000, 0, 0, 0));
        vecs.push_back(mk(2, 0, 1, 1, 0, 'h200, 'h055, 'h000, 'h056, 0, 0, 0, 0, 'h000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 'h000, 'h000, 'h000, 'h200, 1, 0, 0, 0, 'h000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 'h000, 'h000, 'h000, 'h201, 0, 0, 0, 0, 'h000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 'h000, 'h000, 'h000, 'h202, 0, 0, 1, 0, 'h202, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 'h000, 'h000, 'h000, 'h004, 1, 1, 0, 0, 'h000, 1, 0, 0));
        vecs.push_back(mk(4, 0, 0, 0, 0, 'h000, 'h005, 'h202, 'h005, 0, 0, 0, 1, 'h000, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 'h000, 'h000, 'h000, 'h202, 1, 0, 0, 0, 'h000, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 'h300, 'h100, 'h000, 'h203, 0, 0, 0, 0, 'h000, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 'h300, 'h100, 'h000, 'h203, 0, 0, 0, 0, 'h000, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 'h300, 'h100, 'h000, 'h203, 0, 0, 0, 0, 'h000, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 'h300, 'h100, 'h000, 'h203, 0, 0, 1, 0, 'h101, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 'h000, 'h000, 'h000, 'h300, 1, 0, 0, 0, 'h000, 1, 0, 0));
        vecs.push_back(mk(6, 0, 0, 0, 0, 'h400, 'h301, 'h777, 'h301, 0, 0, 1, 0, 'h302, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 'h000, 'h000, 'h000, 'h400, 1, 0, 0, 0, 'h000, 2, 0, 0));
        vecs.push_back(mk(2, 0, 0, 0, 0, 'h7FF, 'h400, 'h000, 'h401, 0, 0, 0, 0, 'h000, 2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 'h000, 'h000, 'h000, 'h7FF, 1, 0, 0, 0, 'h000, 2, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 'h010, 'h7FF, 'h000, 'h000, 0, 0, 1, 0, 'h000, 2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 'h000, 'h000, 'h000, 'h010, 1, 0, 0, 0, 'h000, 3, 0, 0));

        idle_inputs();
        reset = 1'b1;
        #2;
        chk("reset_state", 33'({pc, flush, int_ack, stack_push, stack_pop, depth,
                                stk_overflow, stk_underflow}),
            33'({11'h000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0}));
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {pc, flush, int_ack, stack_push, stack_pop, stack_data, depth,
                 stk_overflow, stk_underflow},
                {vecs[i].e_pc, vecs[i].e_fl, vecs[i].e_ack, vecs[i].e_push, vecs[i].e_pop,
                 vecs[i].e_data, vecs[i].e_dep, vecs[i].e_ovf, vecs[i].e_unf});
            @(posedge clk);
            #1;
        end

        // Asynchronous reset mid-stream.
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("async_reset", 33'({pc, flush, depth, stack_push}),
            33'({11'h000, 1'b1, 5'd0, 1'b0}));
        @(posedge clk);
        #1 reset = 1'b0;

        ok = 1'b0;
        for (int k = 0; k < 4 && !ok; k++) begin
            @(posedge clk);
            #1;
            if (!flush) ok = 1'b1;
        end
        chk("flush_release", 33'(ok), 33'(1'b1));

        // 17 unflushed CALLs: depth saturates at 16 and overflow latches.
        for (int i = 0; i < 17; i++) begin
            ex_call = 1; ex_pc = 11'(i); ex_target = 11'(16'h100 + i);
            #3;
            chk($sformatf("ovf_push%0d", i), 33'({stack_push, stack_data}),
                33'({1'b1, 11'(i + 1)}));
            @(posedge clk);
            #1 ex_call = 0;
            @(posedge clk);
            #1;
        end
        chk("ovf_state", 33'({depth, stk_overflow, stk_underflow}), 33'({5'd16, 1'b1, 1'b0}));

        for (int i = 0; i < 16; i++) begin
            ex_ret = 1; stack_out = 11'(16'h200 + i);
            @(posedge clk);
            #1 ex_ret = 0;
            @(posedge clk);
            #1;
        end
        chk("drained", 33'({depth, stk_underflow}), 33'({5'd0, 1'b0}));

        // RETURN at depth 0: pop still issued, pc takes stack_out, underflow latches.
        ex_ret = 1; stack_out = 11'h2AA;
        #3;
        chk("unf_pop", 33'(stack_pop), 33'(1'b1));
        @(posedge clk);
        #1 ex_ret = 0;
        chk("unf_state", 33'({pc, flush, depth, stk_overflow, stk_underflow}),
            33'({11'h2AA, 1'b1, 5'd0, 1'b1, 1'b1}));
        @(posedge clk);
        #1;

        // err_clr racing a fresh underflow: overflow clears, underflow stays.
        ex_ret = 1; err_clr = 1; stack_out = 11'h155;
        @(posedge clk);
        #1 ex_ret = 0;
        chk("clr_race", 33'({pc, stk_overflow, stk_underflow}), 33'({11'h155, 1'b0, 1'b1}));
        @(posedge clk);
        #1 err_clr = 0;
        chk("clr_flags", 33'({stk_overflow, stk_underflow, depth}), 33'({1'b0, 1'b0, 5'd0}));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
